score_keeper: RTL and testbench
===============================

# score_keeper

Accumulates points for destroyed enemies and maintains the player's score as packed BCD digits for the on-screen score display. It sits directly downstream of the enemy blocks and consumes the per-cycle `add_score_o` counts of enemy1, enemy2 and enemy3. Each count is weighted, then queued in a binary pending accumulator. The queue drains into a saturating BCD counter at one point per cycle, so the display logic never needs a binary-to-BCD converter.

## Interface
- `DIGITS`, 4 — number of BCD score digits.
- `PEND_WIDTH`, 10 — width of the pending-points accumulator.
- `W_ENEMY1`, 1 — points per enemy1 destroyed.
- `W_ENEMY2`, 6 — points per enemy2 destroyed.
- `W_ENEMY3`, 15 — points per enemy3 destroyed.

- `clk_vga`  in  1  — sole clock; all logic runs on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `en_i`  in  1  — game running; when low, new points are ignored.
- `clear_i`  in  1  — synchronous new-game clear.
- `add_score_e1_i`  in  `ADD_SCORE_BIT_WIDTH`  — enemy1 disappearances this cycle.
- `add_score_e2_i`  in  `ADD_SCORE_BIT_WIDTH`  — enemy2 disappearances this cycle.
- `add_score_e3_i`  in  `ADD_SCORE_BIT_WIDTH`  — enemy3 disappearances this cycle.
- `score_bcd_o`  out  4*DIGITS  — current score, packed BCD, most significant digit in the top nibble.
- `high_score_bcd_o`  out  4*DIGITS  — best score since reset (see Configuration).
- `busy_o`  out  1  — pending accumulator is non-zero.
- `milestone_o`  out  1  — one-cycle pulse when the hundreds digit increments.

## Operation
- Reset: all outputs and internal registers go to 0, including score, high score, pending, `busy_o` and `milestone_o`.
- Weighting: `add = e1*W_ENEMY1 + e2*W_ENEMY2 + e3*W_ENEMY3`.
  - The sum is computed at `PEND_WIDTH+2` bits.
  - `add` is forced to 0 when `en_i` is low.
- Pending update: `pending_next = pending + add - drain`, where `drain = (pending != 0)`.
  - If the result exceeds 2^PEND_WIDTH-1, it saturates at 2^PEND_WIDTH-1.
- Drain (one point per cycle while `pending != 0`): ripple-increment the BCD score.
  - Digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit.
  - When the score is all 9s, it holds and the drained point is discarded; `pending` still decrements.
- `milestone_o` pulses in the cycle after any increment that carries into digit 2 (the hundreds digit).
  - Suppressed when DIGITS < 3.
  - Does not fire at saturation.
- Clear: `clear_i` has priority over add and drain.
  - Next edge: score = 0, pending = 0, `milestone_o` = 0.
  - That cycle's adds are discarded.
  - The high score is kept.
- `en_i` low does not stop the drain: queued points still reach the score.

## Timing
- Inputs are sampled at edge N and reach `pending` at edge N, so `busy_o` is high after edge N.
- The first resulting score increment appears after edge N+1; a batch of P points is fully applied after edge N+P.
- `busy_o` is registered and equals `pending != 0`.
- `score_bcd_o` and `high_score_bcd_o` are direct register outputs with no combinational path from the inputs.
- High score: updated at the edge after the score strictly exceeds it (compared as unsigned packed BCD), so it lags the score by one cycle.
- Async `rst` asserted mid-drain: the queue and score are lost immediately; operation restarts cleanly on the first edge after deassertion.

## Configuration
- `SCORE_HIGHSCORE_EN`
  - Defined: the high-score register and comparator are built as described above.
  - Undefined: `high_score_bcd_o` is tied to 0 and no register or comparator is synthesized; all other behaviour is unchanged.

## Test plan
- Reset, then one cycle of `e1=1`, `e2=0`, `e3=0`, `en_i=1` → `busy_o` high for 1 cycle; `score_bcd_o` = 0x0001 after 2 edges; `milestone_o` never fires.
- One cycle of `e3=2` (30 points), then idle → score reaches 0x0030 exactly 31 edges after the sample; `busy_o` falls on the same edge.
- Preload score to 0x0095, add `e2=1` → score steps 0x0096 … 0x0101; `milestone_o` pulses once, in the cycle after 0x0099→0x0100.
- Drive score to 0x9998, add `e3=1` → score holds at 0x9999; `pending` drains to 0 in 15 cycles; no wrap and no `milestone_o`.
- With score 0x0120 and 20 points pending, assert `clear_i` together with `e1=3` → next edge: score 0, `busy_o` 0; high score stays 0x0120 (0 when `SCORE_HIGHSCORE_EN` is undefined).
- `en_i=0` with `e2=1` every cycle while 5 points are pending → the 5 pending points drain and score +5; no further increments.

Source files
------------

// File: rtl/score_keeper.sv
// Weighted enemy-kill scoring: a binary pending queue drains one point per cycle into a
// saturating packed-BCD score. Define SCORE_HIGHSCORE_EN to build the high-score register.
module score_keeper #(
  parameter int DIGITS              = 4,
  parameter int PEND_WIDTH          = 10,
  parameter int W_ENEMY1            = 1,
  parameter int W_ENEMY2            = 6,
  parameter int W_ENEMY3            = 15,
  parameter int ADD_SCORE_BIT_WIDTH = 4
) (
  input  logic                           clk_vga,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic                           clear_i,
  input  logic [ADD_SCORE_BIT_WIDTH-1:0] add_score_e1_i,
  input  logic [ADD_SCORE_BIT_WIDTH-1:0] add_score_e2_i,
  input  logic [ADD_SCORE_BIT_WIDTH-1:0] add_score_e3_i,
  output logic [4*DIGITS-1:0]            score_bcd_o,
  output logic [4*DIGITS-1:0]            high_score_bcd_o,
  output logic                           busy_o,
  output logic                           milestone_o
);

  localparam int SUM_W   = PEND_WIDTH + 2;
  localparam int EXT_W   = SUM_W + 1;
  localparam int SCORE_W = 4 * DIGITS;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  function automatic logic [SUM_W-1:0] weight(
    input logic [ADD_SCORE_BIT_WIDTH-1:0] cnt,
    input logic [SUM_W-1:0]               w
  );
    return SUM_W'(cnt) * w;
  endfunction

  function automatic logic [PEND_WIDTH-1:0] sat_pend(input logic [EXT_W-1:0] v);
    if (v > EXT_W'(PEND_MAX)) return PEND_MAX;
    return v[PEND_WIDTH-1:0];
  endfunction

  logic [SUM_W-1:0]      add_p0;
  logic                  vld_p0;
  logic [PEND_WIDTH-1:0] pending_p1;
  logic [PEND_WIDTH-1:0] pending_next;
  logic                  drain;
  logic [SCORE_W-1:0]    score_p1;
  logic [SCORE_W-1:0]    score_inc;
  logic                  all_nines;
  logic                  hund_carry;
  logic                  carry;
  logic                  busy_p1;
  logic                  milestone_p1;

  // Stage p0: weight this cycle's kill counts
  always_comb begin
    vld_p0 = en_i;
    add_p0 = '0;
    if (vld_p0)
      add_p0 = weight(add_score_e1_i, SUM_W'(W_ENEMY1))
             + weight(add_score_e2_i, SUM_W'(W_ENEMY2))
             + weight(add_score_e3_i, SUM_W'(W_ENEMY3));
  end

  assign drain        = (pending_p1 != '0);
  assign pending_next = sat_pend(EXT_W'(pending_pending_fix(pending_p1)) + EXT_W'(add_p0) - EXT_W'(drain));

  function automatic logic [PEND_WIDTH-1:0] pending_pending_fix(input logic [PEND_WIDTH-1:0] p);
    return p;
  endfunction

  // Ripple BCD increment; hund_carry marks a carry arriving at the hundreds digit
  always_comb begin
    score_inc  = score_p1;
    carry      = 1'b1;
    hund_carry = 1'b0;
    all_nines  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_p1[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (i == 2) hund_carry = carry;
      if (carry) begin
        if (score_p1[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_p1[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Stage p1: pending queue, score and status flags
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      pending_p1   <= '0;
      score_p1     <= '0;
      busy_p1      <= 1'b0;
      milestone_p1 <= 1'b0;
    end else if (clear_i) begin
      pending_p1   <= '0;
      score_p1     <= '0;
      busy_p1      <= 1'b0;
      milestone_p1 <= 1'b0;
    end else begin
      pending_p1   <= pending_next;
      busy_p1      <= (pending_next != '0);
      milestone_p1 <= drain && !all_nines && hund_carry;
      if (drain && !all_nines)
        score_p1 <= score_inc;
    end
  end

  assign score_bcd_o = score_p1;
  assign busy_o      = busy_p1;
  assign milestone_o = milestone_p1;

`ifdef SCORE_HIGHSCORE_EN
  logic [SCORE_W-1:0] high_p2;

  // Stage p2: high score follows the score one cycle late; packed BCD orders like binary
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst)
      high_p2 <= '0;
    else if (score_p1 > high_p2)
      high_p2 <= score_p1;
  end

  assign high_score_bcd_o = high_p2;
`else
  assign high_score_bcd_o = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized self-checking bench for score_keeper against an integer-valued score model.
module tb_score_keeper;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic        en_i;
  logic        clear_i;
  logic [3:0]  e1, e2, e3;
  logic [15:0] score_bcd_o, high_score_bcd_o;
  logic        busy_o, milestone_o;

  int vectors = 0;
  int miscompares = 0;

  int m_score, m_pend, m_high;
  bit m_ms;

  always #5 clk_vga = ~clk_vga;

  score_keeper dut (
    .clk_vga          (clk_vga),
    .rst              (rst),
    .en_i             (en_i),
    .clear_i          (clear_i),
    .add_score_e1_i   (e1),
    .add_score_e2_i   (e2),
    .add_score_e3_i   (e3),
    .score_bcd_o      (score_bcd_o),
    .high_score_bcd_o (high_score_bcd_o),
    .busy_o           (busy_o),
    .milestone_o      (milestone_o)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [33:0] exp_vec();
    int hi;
`ifdef SCORE_HIGHSCORE_EN
    hi = m_high;
`else
    hi = 0;
`endif
    return {to_bcd(m_score), to_bcd(hi), (m_pend != 0), m_ms};
  endfunction

  function automatic logic [33:0] act_vec();
    return {score_bcd_o, high_score_bcd_o, busy_o, milestone_o};
  endfunction

  task automatic model_reset();
    m_score = 0; m_pend = 0; m_high = 0; m_ms = 0;
  endtask

  // One clock edge of the game's scoring rules, applied to the inputs currently driven
  task automatic model_edge();
    int old_score, add;
    bit did_drain;
    old_score = m_score;
    if (clear_i) begin
      m_score = 0; m_pend = 0; m_ms = 0;
    end else begin
      add = en_i ? (int'(e1) * 1 + int'(e2) * 6 + int'(e3) * 15) : 0;
      did_drain = (m_pend != 0);
      m_pend = m_pend + add - (did_drain ? 1 : 0);
      if (m_pend > 1023) m_pend = 1023;
      m_ms = 0;
      if (did_drain && m_score < 9999) begin
        m_score = m_score + 1;
        m_ms = (m_score % 100 == 0);
      end
    end
    if (old_score > m_high) m_high = old_score;
  endtask

  task automatic idle_inputs();
    en_i = 1'b1; clear_i = 1'b0; e1 = 0; e2 = 0; e3 = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // Bring the score to n from zero without saturating the queue
  task automatic preload(input int n);
    int rem, guard;
    do_clear();
    rem = n;
    guard = 0;
    while ((rem > 0 || m_pend != 0) && guard < 20000) begin
      idle_inputs();
      if (rem > 0 && m_pend < 200) begin
        if (rem >= 15) begin e3 = 1; rem -= 15; end
        else begin e1 = 4'(rem); rem = 0; end
      end
      tick();
      guard++;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_vga);
    #1;
    vectors++;
    if (act_vec() !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h want %h", act_vec(), 34'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_point();
    idle_inputs();
    e1 = 1;
    tick();
    idle_inputs();
    vectors++;
    if (busy_o !== 1'b1 || score_bcd_o !== 16'h0000) begin
      miscompares++;
      $display("FAIL single_sample busy=%b score=%h want busy=1 score=0000", busy_o, score_bcd_o);
    end
    tick();
    vectors++;
    if (busy_o !== 1'b0 || score_bcd_o !== 16'h0001) begin
      miscompares++;
      $display("FAIL single_drain busy=%b score=%h want busy=0 score=0001", busy_o, score_bcd_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (act_vec() !== exp_vec() || milestone_o !== 1'b0) begin
        miscompares++;
        $display("FAIL single_idle got %h want %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_batch_latency();
    int k;
    do_clear();
    e3 = 2;
    tick();
    idle_inputs();
    k = 1;
    while (score_bcd_o !== 16'h0030 && k < 100) begin
      tick();
      k++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL batch_step got %h want %h", act_vec(), exp_vec());
      end
    end
    vectors++;
    if (k != 31 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL batch_latency edges=%0d busy=%b want edges=31 busy=0", k, busy_o);
    end
  endtask

  task automatic test_milestone();
    int pulses;
    preload(95);
    vectors++;
    if (score_bcd_o !== 16'h0095) begin
      miscompares++;
      $display("FAIL ms_preload got %h want 0095", score_bcd_o);
    end
    e2 = 1;
    tick();
    idle_inputs();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (milestone_o === 1'b1) pulses++;
      vectors++;
      if (act_vec() !== exp_vec() || (milestone_o === 1'b1 && score_bcd_o !== 16'h0100)) begin
        miscompares++;
        $display("FAIL ms_step got %h want %h", act_vec(), exp_vec());
      end
    end
    vectors++;
    if (pulses != 1 || score_bcd_o !== 16'h0101) begin
      miscompares++;
      $display("FAIL ms_count pulses=%0d score=%h want pulses=1 score=0101", pulses, score_bcd_o);
    end
  endtask

  task automatic test_saturation();
    int drain_cycles;
    preload(9998);
    vectors++;
    if (score_bcd_o !== 16'h9998) begin
      miscompares++;
      $display("FAIL sat_preload got %h want 9998", score_bcd_o);
    end
    e3 = 1;
    tick();
    idle_inputs();
    drain_cycles = 0;
    while (busy_o === 1'b1 && drain_cycles < 50) begin
      tick();
      drain_cycles++;
      vectors++;
      if (act_vec() !== exp_vec() || milestone_o !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_step got %h want %h", act_vec(), exp_vec());
      end
    end
    vectors++;
    if (drain_cycles != 15 || score_bcd_o !== 16'h9999) begin
      miscompares++;
      $display("FAIL sat_hold cycles=%0d score=%h want cycles=15 score=9999", drain_cycles, score_bcd_o);
    end
  endtask

  task automatic test_clear();
    logic [15:0] want_hi;
    preload(120);
    repeat (2) tick();
    e3 = 1; e1 = 5;
    tick();
    idle_inputs();
    vectors++;
    if (score_bcd_o !== 16'h0120 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_setup score=%h busy=%b want score=0120 busy=1", score_bcd_o, busy_o);
    end
    clear_i = 1'b1; e1 = 3;
    tick();
    idle_inputs();
`ifdef SCORE_HIGHSCORE_EN
    want_hi = 16'h0120;
`else
    want_hi = 16'h0000;
`endif
    vectors++;
    if (score_bcd_o !== 16'h0000 || busy_o !== 1'b0 || milestone_o !== 1'b0 || high_score_bcd_o !== want_hi) begin
      miscompares++;
      $display("FAIL clear_result score=%h busy=%b high=%h want score=0000 busy=0 high=%h",
               score_bcd_o, busy_o, high_score_bcd_o, want_hi);
    end
  endtask

  task automatic test_enable_low();
    do_clear();
    e1 = 5;
    tick();
    en_i = 1'b0; e1 = 0; e2 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL en_low_step got %h want %h", act_vec(), exp_vec());
      end
    end
    vectors++;
    if (score_bcd_o !== 16'h0005 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_total score=%h busy=%b want score=0005 busy=0", score_bcd_o, busy_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      en_i = ($urandom_range(0, 3) != 0);
      clear_i = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        e1 = 4'($urandom_range(0, 15));
        e2 = 4'($urandom_range(0, 15));
        e3 = 4'($urandom_range(0, 15));
      end
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_%0d got %h want %h", i, act_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    preload(40);
    e3 = 5;
    tick();
    idle_inputs();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (act_vec() !== 34'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want %h", act_vec(), 34'd0);
    end
    @(posedge clk_vga);
    #1;
    rst = 1'b0;
    e1 = 1;
    tick();
    idle_inputs();
    tick();
    vectors++;
    if (act_vec() !== exp_vec() || score_bcd_o !== 16'h0001) begin
      miscompares++;
      $display("FAIL async_restart got %h want %h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    @(posedge clk_vga);
    #1;
    test_single_point();
    test_batch_latency();
    test_milestone();
    test_enable_low();
    test_clear();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
